// File: rtl/traffic_fsm_if.sv
// Timer link bundle between traffic_fsm and the downstream timer.
//   timer_done     : timer -> fsm, dwell elapsed (held until next reload)
//   timer_load_val : fsm -> timer, dwell in beats for the reload
//   timer_rst      : fsm -> timer, active-high one-cycle reload strobe
// Modports: master = traffic_fsm side, slave = timer side.
interface traffic_fsm_if;
   localparam int unsigned DWELL_W = 4;

   logic               timer_done;
   logic [DWELL_W-1:0] timer_load_val;
   logic               timer_rst;

   modport master (input timer_done, output timer_load_val, output timer_rst);
   modport slave  (output timer_done, input timer_load_val, input timer_rst);
endinterface

// File: rtl/traffic_fsm.sv
// Light-sequencing controller driving a downstream beat timer.
// Each phase reloads the timer with its dwell and waits for the timer's done.
// Optional pedestrian walk phase enabled by defining TRAFFIC_FSM_WALK_EN.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   side_sensor     : car waiting on side road (sampled at expiry)
//   walk_btn        : pedestrian request (latched when walk is enabled)
//   tmr             : timer link (done in, load value / reload strobe out)
//   main_light      : main road one-hot {R,Y,G}
//   side_light      : side road one-hot {R,Y,G}
//   walk_light      : pedestrian walk lamp
//   state_dbg       : current state encoding
module traffic_fsm #(
   parameter logic [3:0] MAIN_GREEN_T = 4'd8,
   parameter logic [3:0] SIDE_GREEN_T = 4'd5,
   parameter logic [3:0] SIDE_EXT_T   = 4'd3,
   parameter logic [3:0] YELLOW_T     = 4'd2,
   parameter logic [3:0] ALL_RED_T    = 4'd1,
   parameter logic [3:0] WALK_T       = 4'd6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             side_sensor,
   input  logic             walk_btn,
   traffic_fsm_if.master    tmr,
   output logic [2:0]       main_light,
   output logic [2:0]       side_light,
   output logic             walk_light,
   output logic [2:0]       state_dbg
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned DWELL_W = 4;
   localparam int unsigned LIGHT_W = 3;

   localparam logic [LIGHT_W-1:0] LT_R = 3'b100;
   localparam logic [LIGHT_W-1:0] LT_Y = 3'b010;
   localparam logic [LIGHT_W-1:0] LT_G = 3'b001;

   typedef enum logic [STATE_W-1:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALL_RED1    = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      ALL_RED2    = 3'd5,
      WALK        = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ext_used;
   logic                 w_ext_nxt;
   logic                 r_timer_rst;
   logic                 w_timer_rst_nxt;
   logic [DWELL_W-1:0]   r_load_val;
   logic [DWELL_W-1:0]   w_load_nxt;
   logic [LIGHT_W-1:0]   r_main_light;
   logic [LIGHT_W-1:0]   w_main_nxt;
   logic [LIGHT_W-1:0]   r_side_light;
   logic [LIGHT_W-1:0]   w_side_nxt;
   logic                 r_walk_light;
   logic                 w_walk_light_nxt;
   logic                 w_walk_req;
   logic                 w_expired;
   logic                 w_enter;

   // Zero dwell would never expire cleanly; treat it as one beat.
   function automatic logic [DWELL_W-1:0] clamp(input logic [DWELL_W-1:0] v);
      return (v == 4'd0) ? 4'd1 : v;
   endfunction

   function automatic logic [DWELL_W-1:0] dwell(input state_t s);
      case (s)
         MAIN_GREEN:  return clamp(MAIN_GREEN_T);
         MAIN_YELLOW: return clamp(YELLOW_T);
         SIDE_GREEN:  return clamp(SIDE_GREEN_T);
         SIDE_YELLOW: return clamp(YELLOW_T);
         WALK:        return clamp(WALK_T);
         default:     return clamp(ALL_RED_T);
      endcase
   endfunction

   // Stale done from the previous phase is masked during the reload strobe.
   assign w_expired = tmr.timer_done & ~r_timer_rst;

`ifdef TRAFFIC_FSM_WALK_EN
   logic r_walk_req;
   logic w_walk_req_nxt;

   // Press on the WALK-entry cycle re-arms the request for the next round.
   always_comb begin
      w_walk_req_nxt = r_walk_req | walk_btn;
      if (w_enter && (w_state_nxt == WALK)) w_walk_req_nxt = walk_btn;
   end

   always_ff @(posedge clk) begin
      if (!rst) r_walk_req <= 1'b0;
      else      r_walk_req <= w_walk_req_nxt;
   end

   assign w_walk_req = r_walk_req;
`else
   logic w_unused_walk_btn;
   assign w_unused_walk_btn = walk_btn;
   assign w_walk_req        = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ALL_RED2;
         r_ext_used   <= 1'b0;
         r_timer_rst  <= 1'b1;
         r_load_val   <= clamp(ALL_RED_T);
         r_main_light <= LT_R;
         r_side_light <= LT_R;
         r_walk_light <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ext_used   <= w_ext_nxt;
         r_timer_rst  <= w_timer_rst_nxt;
         r_load_val   <= w_load_nxt;
         r_main_light <= w_main_nxt;
         r_side_light <= w_side_nxt;
         r_walk_light <= w_walk_light_nxt;
      end
   end

   // Next-state, reload and light decode.
   always_comb begin
      w_state_nxt      = r_state;
      w_ext_nxt        = r_ext_used;
      w_timer_rst_nxt  = 1'b0;
      w_load_nxt       = r_load_val;
      w_enter          = 1'b0;
      w_main_nxt       = LT_R;
      w_side_nxt       = LT_R;
      w_walk_light_nxt = 1'b0;

      if (w_expired) begin
         case (r_state)
            MAIN_GREEN: begin
               if (side_sensor || w_walk_req) begin
                  w_state_nxt = MAIN_YELLOW;
                  w_enter     = 1'b1;
               end
            end
            MAIN_YELLOW: begin
               w_state_nxt = ALL_RED1;
               w_enter     = 1'b1;
            end
            ALL_RED1: begin
               w_state_nxt = SIDE_GREEN;
               w_enter     = 1'b1;
            end
            SIDE_GREEN: begin
               if (side_sensor && !r_ext_used) begin
                  w_ext_nxt       = 1'b1;
                  w_timer_rst_nxt = 1'b1;
                  w_load_nxt      = clamp(SIDE_EXT_T);
               end else begin
                  w_state_nxt = SIDE_YELLOW;
                  w_enter     = 1'b1;
               end
            end
            SIDE_YELLOW: begin
               w_state_nxt = ALL_RED2;
               w_enter     = 1'b1;
            end
            ALL_RED2: begin
               w_state_nxt = w_walk_req ? WALK : MAIN_GREEN;
               w_enter     = 1'b1;
            end
            default: begin
               w_state_nxt = MAIN_GREEN;
               w_enter     = 1'b1;
            end
         endcase
      end

      if (w_enter) begin
         w_timer_rst_nxt = 1'b1;
         w_load_nxt      = dwell(w_state_nxt);
         if (w_state_nxt == SIDE_GREEN) w_ext_nxt = 1'b0;
      end

      case (w_state_nxt)
         MAIN_GREEN:  w_main_nxt = LT_G;
         MAIN_YELLOW: w_main_nxt = LT_Y;
         SIDE_GREEN:  w_side_nxt = LT_G;
         SIDE_YELLOW: w_side_nxt = LT_Y;
         default:     ;
      endcase
`ifdef TRAFFIC_FSM_WALK_EN
      w_walk_light_nxt = (w_state_nxt == WALK);
`endif
   end

   assign tmr.timer_rst      = r_timer_rst;
   assign tmr.timer_load_val = r_load_val;
   assign main_light         = r_main_light;
   assign side_light         = r_side_light;
   assign walk_light         = r_walk_light;
   assign state_dbg          = STATE_W'(r_state);

endmodule
